// File: rtl/baud_pkg.sv
// Shared constants and types for the fractional UART baud generator.
// Defaults target a 25 MHz system clock at 115200 baud, 16x oversampling.
package baud_pkg;

  localparam int unsigned DIV_INT_W    = 16;
  localparam int unsigned DIV_FRAC_W   = 4;
  localparam int unsigned OVERSAMPLE   = 16;

  // 25e6 / (115200 * 16) = 13.5634 -> 13 + 9/16
  localparam int unsigned RST_DIV_INT  = 13;
  localparam int unsigned RST_DIV_FRAC = 9;

  // Width of the oversample phase counter for the default ratio.
  localparam int unsigned OS_PHASE_W   = $clog2(OVERSAMPLE);

  // Per-cycle action of the fractional divider, resolved in priority order.
  typedef enum logic [2:0] {
    OP_RESET,
    OP_RESYNC,
    OP_LOAD_NOW,
    OP_LOAD_SHADOW,
    OP_COUNT,
    OP_HOLD
  } div_op_e;

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: counter, fractional accumulator, active and
// shadow divisor registers with boundary-aligned reload.
// adv_o is a combinational strobe asserted in the cycle whose clock edge
// produces the next oversample tick; tick_o is the registered pulse.
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int unsigned DIV_INT_W    = baud_pkg::DIV_INT_W,
  parameter int unsigned DIV_FRAC_W   = baud_pkg::DIV_FRAC_W,
  parameter int unsigned RST_DIV_INT  = baud_pkg::RST_DIV_INT,
  parameter int unsigned RST_DIV_FRAC = baud_pkg::RST_DIV_FRAC
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  resync_i,
  input  logic [DIV_INT_W-1:0]  div_int_i,
  input  logic [DIV_FRAC_W-1:0] div_frac_i,
  input  logic                  div_load_i,
  output logic                  div_pend_o,
  output logic                  tick_o,
  output logic                  adv_o
);

  logic [DIV_INT_W-1:0]  cnt_q;
  logic [DIV_INT_W-1:0]  act_int_q;
  logic [DIV_INT_W-1:0]  sh_int_q;
  logic [DIV_FRAC_W-1:0] acc_q;
  logic [DIV_FRAC_W-1:0] act_frac_q;
  logic [DIV_FRAC_W-1:0] sh_frac_q;
  logic                  pend_q;
  logic                  tick_q;

  logic [DIV_INT_W-1:0]  eff_int;
  logic [DIV_FRAC_W-1:0] eff_frac;
  logic [DIV_FRAC_W:0]   sum;
  logic [DIV_INT_W:0]    len_m1;
  logic                  term;
  div_op_e               op;

  // Effective divisor and terminal-count detection; len-1 is kept one bit
  // wider so an all-ones divisor plus carry wraps the counter naturally.
  always_comb begin
    eff_int  = act_int_q;
    eff_frac = act_frac_q;
    if (act_int_q == '0) begin
      eff_int  = DIV_INT_W'(1);
      eff_frac = '0;
    end
    sum    = {1'b0, acc_q} + {1'b0, eff_frac};
    len_m1 = {1'b0, eff_int} + {{DIV_INT_W{1'b0}}, sum[DIV_FRAC_W]}
             - (DIV_INT_W+1)'(1);
    term   = ({1'b0, cnt_q} == len_m1);
  end

  // Resolve the action for this cycle: reset > resync > load > count.
  always_comb begin
    op = OP_HOLD;
    if (rst_i)                  op = OP_RESET;
    else if (resync_i)          op = OP_RESYNC;
    else if (div_load_i && !en_i) op = OP_LOAD_NOW;
    else if (div_load_i)        op = OP_LOAD_SHADOW;
    else if (en_i)              op = OP_COUNT;
  end

  assign adv_o = term && ((op == OP_COUNT) || (op == OP_LOAD_SHADOW));

  // Divider state update.
  always_ff @(posedge clk_i) begin
    case (op)
      OP_RESET: begin
        cnt_q      <= '0;
        acc_q      <= '0;
        act_int_q  <= DIV_INT_W'(RST_DIV_INT);
        act_frac_q <= DIV_FRAC_W'(RST_DIV_FRAC);
        sh_int_q   <= '0;
        sh_frac_q  <= '0;
        pend_q     <= 1'b0;
        tick_q     <= 1'b0;
      end
      OP_RESYNC: begin
        cnt_q  <= '0;
        acc_q  <= '0;
        tick_q <= 1'b0;
        if (pend_q) begin
          act_int_q  <= sh_int_q;
          act_frac_q <= sh_frac_q;
          pend_q     <= 1'b0;
        end
      end
      OP_LOAD_NOW: begin
        act_int_q  <= div_int_i;
        act_frac_q <= div_frac_i;
        acc_q      <= '0;
        pend_q     <= 1'b0;
        tick_q     <= 1'b0;
      end
      // A load landing on a terminal count finishes with the old divisor
      // and waits for the following boundary.
      OP_LOAD_SHADOW: begin
        sh_int_q  <= div_int_i;
        sh_frac_q <= div_frac_i;
        pend_q    <= 1'b1;
        if (term) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          acc_q  <= sum[DIV_FRAC_W-1:0];
        end else begin
          cnt_q  <= cnt_q + DIV_INT_W'(1);
          tick_q <= 1'b0;
        end
      end
      OP_COUNT: begin
        if (term) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          if (pend_q) begin
            act_int_q  <= sh_int_q;
            act_frac_q <= sh_frac_q;
            acc_q      <= '0;
            pend_q     <= 1'b0;
          end else begin
            acc_q <= sum[DIV_FRAC_W-1:0];
          end
        end else begin
          cnt_q  <= cnt_q + DIV_INT_W'(1);
          tick_q <= 1'b0;
        end
      end
      default: begin
        tick_q <= 1'b0;
      end
    endcase
  end

  assign div_pend_o = pend_q;
  assign tick_o     = tick_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Runtime-programmable UART baud generator with fractional divisor.
// Produces an oversample tick, a 1x baud tick and the oversample phase.
// Optional macro BAUD_GEN_MID_TICK_EN adds a mid-bit strobe on tick_mid_o;
// without it tick_mid_o is tied low.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned DIV_INT_W    = baud_pkg::DIV_INT_W,
  parameter int unsigned DIV_FRAC_W   = baud_pkg::DIV_FRAC_W,
  parameter int unsigned OVERSAMPLE   = baud_pkg::OVERSAMPLE,
  parameter int unsigned RST_DIV_INT  = baud_pkg::RST_DIV_INT,
  parameter int unsigned RST_DIV_FRAC = baud_pkg::RST_DIV_FRAC
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          resync_i,
  input  logic [DIV_INT_W-1:0]          div_int_i,
  input  logic [DIV_FRAC_W-1:0]         div_frac_i,
  input  logic                          div_load_i,
  output logic                          div_pend_o,
  output logic                          tick_os_o,
  output logic                          tick_1x_o,
  output logic                          tick_mid_o,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase_o
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);

  logic            adv;
  logic [PH_W-1:0] os_phase_q;
  logic [PH_W-1:0] os_phase_d;
  logic            tick_1x_q;

  baud_frac_div #(
    .DIV_INT_W    (DIV_INT_W),
    .DIV_FRAC_W   (DIV_FRAC_W),
    .RST_DIV_INT  (RST_DIV_INT),
    .RST_DIV_FRAC (RST_DIV_FRAC)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .resync_i   (resync_i),
    .div_int_i  (div_int_i),
    .div_frac_i (div_frac_i),
    .div_load_i (div_load_i),
    .div_pend_o (div_pend_o),
    .tick_o     (tick_os_o),
    .adv_o      (adv)
  );

  assign os_phase_d = os_phase_q + PH_W'(1);

  // Oversample phase and 1x tick, registered alongside the os tick.
  always_ff @(posedge clk_i) begin
    if (rst_i || resync_i) begin
      os_phase_q <= '0;
      tick_1x_q  <= 1'b0;
    end else if (adv) begin
      os_phase_q <= os_phase_d;
      tick_1x_q  <= (os_phase_q == PH_W'(OVERSAMPLE - 1));
    end else begin
      tick_1x_q  <= 1'b0;
    end
  end

`ifdef BAUD_GEN_MID_TICK_EN
  logic tick_mid_q;

  // Mid-bit strobe on the os tick that moves the phase to OVERSAMPLE/2.
  always_ff @(posedge clk_i) begin
    if (rst_i || resync_i) begin
      tick_mid_q <= 1'b0;
    end else if (adv) begin
      tick_mid_q <= (os_phase_d == PH_W'(OVERSAMPLE / 2));
    end else begin
      tick_mid_q <= 1'b0;
    end
  end

  assign tick_mid_o = tick_mid_q;
`else
  assign tick_mid_o = 1'b0;
`endif

  assign tick_1x_o  = tick_1x_q;
  assign os_phase_o = os_phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac (default parameters).
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        resync_i = 1'b0;
  logic [15:0] div_int_i = '0;
  logic [3:0]  div_frac_i = '0;
  logic        div_load_i = 1'b0;
  logic        div_pend_o;
  logic        tick_os_o;
  logic        tick_1x_o;
  logic        tick_mid_o;
  logic [3:0]  os_phase_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit pend_seen = 0;
  bit mid_seen  = 0;

  always #5 clk = ~clk;

  baud_gen_frac dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .resync_i   (resync_i),
    .div_int_i  (div_int_i),
    .div_frac_i (div_frac_i),
    .div_load_i (div_load_i),
    .div_pend_o (div_pend_o),
    .tick_os_o  (tick_os_o),
    .tick_1x_o  (tick_1x_o),
    .tick_mid_o (tick_mid_o),
    .os_phase_o (os_phase_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (div_pend_o === 1'b1) pend_seen = 1;
    if (tick_mid_o === 1'b1) mid_seen = 1;
  endtask

  // Edges until the next os tick is visible; 200 means it never came.
  task automatic wait_os(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick_os_o !== 1'b1 && n < 200);
  endtask

  task automatic do_reset(input bit en_v);
    rst_i = 1'b1; en_i = en_v; resync_i = 1'b0; div_load_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic load_idle(input int di, input int df);
    en_i = 1'b0; div_int_i = 16'(di); div_frac_i = 4'(df); div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1;
    step(); step();
    chk_cnt++; if (tick_os_o !== 1'b0) $display("FAIL reset_tick_os: got %b want 0", tick_os_o); else pass_cnt++;
    chk_cnt++; if (tick_1x_o !== 1'b0) $display("FAIL reset_tick_1x: got %b want 0", tick_1x_o); else pass_cnt++;
    chk_cnt++; if (tick_mid_o !== 1'b0) $display("FAIL reset_tick_mid: got %b want 0", tick_mid_o); else pass_cnt++;
    chk_cnt++; if (os_phase_o !== 4'd0) $display("FAIL reset_phase: got %0d want 0", os_phase_o); else pass_cnt++;
    chk_cnt++; if (div_pend_o !== 1'b0) $display("FAIL reset_pend: got %b want 0", div_pend_o); else pass_cnt++;
  endtask

  // Default 13/9: accumulator carries give 9 long periods in 16.
  task automatic test_default();
    int exp_len [16] = '{13,14,13,14,13,14,13,14,14,13,14,13,14,13,14,14};
    int n;
    int total = 0;
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      wait_os(n);
      total += n;
      chk_cnt++; if (n !== exp_len[i]) $display("FAIL default_period[%0d]: got %0d want %0d", i, n, exp_len[i]); else pass_cnt++;
      chk_cnt++; if (tick_1x_o !== (i == 15)) $display("FAIL default_1x[%0d]: got %b want %b", i, tick_1x_o, (i == 15)); else pass_cnt++;
`ifdef BAUD_GEN_MID_TICK_EN
      chk_cnt++; if (tick_mid_o !== (i == 7)) $display("FAIL default_mid[%0d]: got %b want %b", i, tick_mid_o, (i == 7)); else pass_cnt++;
`endif
      if (i == 7) begin
        chk_cnt++; if (os_phase_o !== 4'd8) $display("FAIL default_phase8: got %0d want 8", os_phase_o); else pass_cnt++;
      end
    end
    chk_cnt++; if (total !== 217) $display("FAIL default_total: got %0d want 217", total); else pass_cnt++;
    chk_cnt++; if (os_phase_o !== 4'd0) $display("FAIL default_phase_wrap: got %0d want 0", os_phase_o); else pass_cnt++;
  endtask

  task automatic test_load_idle();
    int n;
    do_reset(1'b0);
    pend_seen = 0;
    load_idle(10, 0);
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_os(n);
      chk_cnt++; if (n !== 10) $display("FAIL idle_load_period[%0d]: got %0d want 10", i, n); else pass_cnt++;
    end
    chk_cnt++; if (pend_seen !== 1'b0) $display("FAIL idle_load_pend: got %b want 0", pend_seen); else pass_cnt++;
  endtask

  task automatic test_reload_pending();
    int n;
    load_idle(13, 0);
    en_i = 1'b1;
    wait_os(n);
    chk_cnt++; if (n !== 13) $display("FAIL reload_base: got %0d want 13", n); else pass_cnt++;
    repeat (11) step();
    div_int_i = 16'd20; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    chk_cnt++; if (div_pend_o !== 1'b1) $display("FAIL reload_pend_set: got %b want 1", div_pend_o); else pass_cnt++;
    wait_os(n);
    chk_cnt++; if (n !== 1) $display("FAIL reload_old_period_end: got %0d want 1", n); else pass_cnt++;
    chk_cnt++; if (div_pend_o !== 1'b0) $display("FAIL reload_pend_clr: got %b want 0", div_pend_o); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      wait_os(n);
      chk_cnt++; if (n !== 20) $display("FAIL reload_new_period[%0d]: got %0d want 20", i, n); else pass_cnt++;
    end
    // Two loads while pending: the second one is the one applied.
    div_int_i = 16'd30; div_load_i = 1'b1; step();
    div_int_i = 16'd7;  step();
    div_load_i = 1'b0;
    wait_os(n);
    chk_cnt++; if (n !== 18) $display("FAIL lastwrite_old_period: got %0d want 18", n); else pass_cnt++;
    wait_os(n);
    chk_cnt++; if (n !== 7) $display("FAIL lastwrite_new_period: got %0d want 7", n); else pass_cnt++;
  endtask

  task automatic test_resync();
    int n;
    do_reset(1'b0);
    load_idle(13, 0);
    en_i = 1'b1;
    repeat (7) wait_os(n);
    chk_cnt++; if (os_phase_o !== 4'd7) $display("FAIL resync_pre_phase: got %0d want 7", os_phase_o); else pass_cnt++;
    repeat (5) step();
    resync_i = 1'b1; step(); resync_i = 1'b0;
    chk_cnt++; if (os_phase_o !== 4'd0) $display("FAIL resync_phase: got %0d want 0", os_phase_o); else pass_cnt++;
    chk_cnt++; if (tick_os_o !== 1'b0) $display("FAIL resync_tick: got %b want 0", tick_os_o); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      wait_os(n);
      chk_cnt++; if (n !== 13) $display("FAIL resync_period[%0d]: got %0d want 13", i, n); else pass_cnt++;
      chk_cnt++; if (tick_1x_o !== (i == 15)) $display("FAIL resync_1x[%0d]: got %b want %b", i, tick_1x_o, (i == 15)); else pass_cnt++;
    end
    // Resync applies a pending divisor at once.
    div_int_i = 16'd20; div_load_i = 1'b1; step(); div_load_i = 1'b0;
    chk_cnt++; if (div_pend_o !== 1'b1) $display("FAIL resync_pend_set: got %b want 1", div_pend_o); else pass_cnt++;
    repeat (3) step();
    resync_i = 1'b1; step(); resync_i = 1'b0;
    chk_cnt++; if (div_pend_o !== 1'b0) $display("FAIL resync_pend_clr: got %b want 0", div_pend_o); else pass_cnt++;
    wait_os(n);
    chk_cnt++; if (n !== 20) $display("FAIL resync_apply_period: got %0d want 20", n); else pass_cnt++;
  endtask

  task automatic test_en_gate();
    int n;
    bit quiet = 1;
    do_reset(1'b0);
    load_idle(13, 0);
    en_i = 1'b1;
    wait_os(n);
    repeat (6) step();
    en_i = 1'b0;
    repeat (5) begin
      step();
      if (tick_os_o !== 1'b0 || tick_1x_o !== 1'b0) quiet = 0;
    end
    chk_cnt++; if (quiet !== 1'b1) $display("FAIL gate_quiet: got %b want 1", quiet); else pass_cnt++;
    en_i = 1'b1;
    wait_os(n);
    chk_cnt++; if (n !== 7) $display("FAIL gate_resume: got %0d want 7", n); else pass_cnt++;
    // Reset while a load is pending restores the default 13/9.
    div_int_i = 16'd20; div_load_i = 1'b1; step(); div_load_i = 1'b0;
    chk_cnt++; if (div_pend_o !== 1'b1) $display("FAIL rstpend_set: got %b want 1", div_pend_o); else pass_cnt++;
    rst_i = 1'b1; step();
    chk_cnt++; if (div_pend_o !== 1'b0) $display("FAIL rstpend_clr: got %b want 0", div_pend_o); else pass_cnt++;
    rst_i = 1'b0;
    wait_os(n);
    chk_cnt++; if (n !== 13) $display("FAIL rstpend_period0: got %0d want 13", n); else pass_cnt++;
    wait_os(n);
    chk_cnt++; if (n !== 14) $display("FAIL rstpend_period1: got %0d want 14", n); else pass_cnt++;
  endtask

  task automatic test_degenerate();
    int n;
    load_idle(0, 5);
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_os(n);
      chk_cnt++; if (n !== 1) $display("FAIL degenerate_period[%0d]: got %0d want 1", i, n); else pass_cnt++;
    end
  endtask

  task automatic test_mid_default();
`ifndef BAUD_GEN_MID_TICK_EN
    chk_cnt++; if (mid_seen !== 1'b0) $display("FAIL mid_tied_low: got %b want 0", mid_seen); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_default();
    test_load_idle();
    test_reload_pending();
    test_resync();
    test_en_gate();
    test_degenerate();
    test_mid_default();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
